// File: rtl/i2c_controller_read.sv
// ---------------------------------------------------------------------------
// i2c_controller_read
//
// I2C master read controller for the wb_i2c peripheral. On start it issues a
// START condition, sends the 7-bit address with R/W=1, checks the slave ACK,
// clocks in one or two data bytes (master ACK between bytes, NACK after the
// last) and finishes with a STOP. Everything runs on clk; bus timing comes
// from a divisor-based tick enable and a 128-phase bit period.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   divisor    in   tick period is divisor+1 clk cycles (captured at start)
//   start      in   level; accepted on any clk while idle
//   addr       in   7-bit slave address (captured at start)
//   two_bytes  in   1 = read two bytes, 0 = read one byte (captured at start)
//   i2c_sclk   out  SCL
//   i2c_sdat   io   SDA, open drain (drives 0 or Z)
//   busy       out  transaction in progress
//   done       out  high from transaction end until the next accepted start
//   ack        out  slave acknowledged its address in the last transaction
//   rd_data    out  {byte1, byte2} or {8'h00, byte1}
//   data_valid out  one-clk pulse when rd_data updates
// ---------------------------------------------------------------------------
module i2c_controller_read (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  divisor,
    input  logic        start,
    input  logic [6:0]  addr,
    input  logic        two_bytes,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic        busy,
    output logic        done,
    output logic        ack,
    output logic [15:0] rd_data,
    output logic        data_valid
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA1,
        S_MACK1, S_DATA2, S_MACK2, S_STOP, S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [6:0]  r_div;
    logic [6:0]  r_tick_cnt;
    logic [6:0]  r_phase;
    logic [2:0]  r_bit_cnt;
    logic        r_clk_en;
    logic        r_sda_low;
    logic        r_sda_s1;
    logic        r_sda_s2;
    logic [6:0]  r_addr;
    logic        r_two;
    logic [15:0] r_rx;
    logic        r_busy;
    logic        r_done;
    logic        r_ack;
    logic [15:0] r_rd_data;
    logic        r_dv;

    logic        w_tick;
    logic        w_mid_low;
    logic        w_mid_high;
    logic        w_end;
    logic        w_start_ok;
    logic        w_last_bit;
    logic        w_sda_val;
    logic [7:0]  w_tx;
    logic        w_is_data;

    assign w_tick     = r_busy && (r_tick_cnt == r_div);
    assign w_mid_low  = w_tick && (r_phase == 7'd31);
    assign w_mid_high = w_tick && (r_phase == 7'd95);
    assign w_end      = w_tick && (r_phase == 7'd127);
    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_tx       = {r_addr, 1'b1};
    assign w_is_data  = (r_state == S_DATA1) || (r_state == S_DATA2);

    // SCL is held high whenever the clock is not enabled (idle, START, FIN).
    assign i2c_sclk = ~r_clk_en | r_phase[6];
    assign i2c_sdat = r_sda_low ? 1'b0 : 1'bz;

    assign busy       = r_busy;
    assign done       = r_done;
    assign ack        = r_ack;
    assign rd_data    = r_rd_data;
    assign data_valid = r_dv;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and the SDA level to apply at the next mid-low point
    always_comb begin
        w_next    = r_state;
        w_sda_val = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_START;
            S_START: begin
                w_sda_val = 1'b1;
                if (w_end) w_next = S_ADDR;
            end
            S_ADDR: begin
                w_sda_val = ~w_tx[3'd7 - r_bit_cnt];
                if (w_end && w_last_bit) w_next = S_AACK;
            end
            S_AACK:  if (w_end) w_next = r_ack ? S_DATA1 : S_STOP;
            S_DATA1: if (w_end && w_last_bit) w_next = S_MACK1;
            S_MACK1: begin
                w_sda_val = r_two;
                if (w_end) w_next = r_two ? S_DATA2 : S_STOP;
            end
            S_DATA2: if (w_end && w_last_bit) w_next = S_MACK2;
            S_MACK2: if (w_end) w_next = S_STOP;
            S_STOP: begin
                w_sda_val = 1'b1;
                if (w_end) w_next = S_FIN;
            end
            S_FIN:   if (w_mid_low) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Two-flop synchronizer on the incoming SDA level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_sda_s1 <= i2c_sdat;
            r_sda_s2 <= r_sda_s1;
        end
    end

    // Timing counters, bus drive and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div      <= '0;
            r_tick_cnt <= '0;
            r_phase    <= '0;
            r_bit_cnt  <= '0;
            r_clk_en   <= 1'b0;
            r_sda_low  <= 1'b0;
            r_addr     <= '0;
            r_two      <= 1'b0;
            r_rx       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack      <= 1'b0;
            r_rd_data  <= '0;
            r_dv       <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            if (w_start_ok) begin
                r_div      <= divisor;
                r_addr     <= addr;
                r_two      <= two_bytes;
                r_tick_cnt <= '0;
                r_phase    <= '0;
                r_bit_cnt  <= '0;
                r_rx       <= '0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
            end else if (r_busy) begin
                r_tick_cnt <= w_tick ? 7'd0 : r_tick_cnt + 7'd1;
                if (w_tick) r_phase <= r_phase + 7'd1;

                if (w_mid_low) r_sda_low <= w_sda_val;

                if (w_mid_high) begin
                    if (r_state == S_AACK) r_ack <= ~r_sda_s2;
                    if (w_is_data)         r_rx  <= {r_rx[14:0], r_sda_s2};
                end

                // The bit counter only matters in the 8-period states; it
                // wraps back to 0 on the eighth period end.
                if (w_end) begin
                    if ((r_state == S_ADDR) || w_is_data)
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    else
                        r_bit_cnt <= '0;
                    if (r_state == S_START) r_clk_en <= 1'b1;
                    if (r_state == S_STOP)  r_clk_en <= 1'b0;
                end

                // STOP condition: SDA rises (w_sda_val=0) while SCL is high.
                if (w_mid_low && (r_state == S_FIN)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_ack) begin
                        r_rd_data <= r_rx;
                        r_dv      <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_controller_read.sv
module tb_i2c_controller_read;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  divisor;
    logic        start;
    logic [6:0]  addr;
    logic        two_bytes;
    wire         scl;
    wire         sda;
    logic        busy, done, ack, dv;
    logic [15:0] rd_data;
    logic        slave_low;

    assign sda = slave_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_controller_read dut (
        .clk        (clk),
        .reset      (rst_n),
        .divisor    (divisor),
        .start      (start),
        .addr       (addr),
        .two_bytes  (two_bytes),
        .i2c_sclk   (scl),
        .i2c_sdat   (sda),
        .busy       (busy),
        .done       (done),
        .ack        (ack),
        .rd_data    (rd_data),
        .data_valid (dv)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model of the current transaction: k counts clk edges since the start edge.
    bit          m_active = 1'b0;
    int          m_k, m_T, m_fin, m_kd, m_ka;
    logic [6:0]  m_addr;
    bit          m_two, m_sack;
    logic [7:0]  m_b1, m_b2;
    logic [15:0] m_rd_exp = 16'h0000;
    bit          m_ack_exp = 1'b0;
    int          m_done_k, m_fall_k, m_dv_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d actual=%h expected=%h", nm, m_k, act, exp);
        end
    endtask

    // Bit period whose SDA level is on the bus at edge count k (levels
    // change a quarter period into each period); -1 before the first change.
    function automatic int eidx(input int k);
        if (k < 32 * m_T) return -1;
        return (k - 32 * m_T) / (128 * m_T);
    endfunction

    // Master pulls SDA low during period e?
    function automatic bit mdl_master_low(input int e);
        logic [7:0] tx;
        tx = {m_addr, 1'b1};
        if (e < 0)          return 1'b0;
        if (e == 0)         return 1'b1;        // START
        if (e >= m_fin)     return 1'b0;        // STOP release and idle
        if (e == m_fin - 1) return 1'b1;        // STOP setup low
        if (e <= 8)         return ~tx[3'(8 - e)];
        if (e == 18)        return m_two;       // ACK after first byte
        return 1'b0;
    endfunction

    // Slave pulls SDA low during period e?
    function automatic bit mdl_slave_low(input int e);
        if (e == 9) return m_sack;
        if (!m_sack) return 1'b0;
        if (e >= 10 && e <= 17) return ~m_b1[3'(17 - e)];
        if (m_two && e >= 19 && e <= 26) return ~m_b2[3'(26 - e)];
        return 1'b0;
    endfunction

    // Compare process: every cycle while a transaction (or the idle time
    // following it) is being tracked.
    always @(negedge clk) begin : cmp
        int ph, idx;
        bit e_scl, e_sda;
        if (m_active) begin
            ph  = (m_k / m_T) % 128;
            idx = m_k / (128 * m_T);
            if (m_k == m_ka) m_ack_exp = m_sack;
            if (m_k == m_kd && m_sack)
                m_rd_exp = m_two ? {m_b1, m_b2} : {8'h00, m_b1};
            e_scl = (m_k >= m_kd || idx == 0 || idx == m_fin) ? 1'b1 : (ph >= 64);
            e_sda = !(mdl_master_low(eidx(m_k)) || mdl_slave_low(eidx(m_k)));
            chk("scl",     32'(scl),     32'(e_scl));
            chk("sda",     32'(sda),     32'(e_sda));
            chk("busy",    32'(busy),    32'(m_k < m_kd));
            chk("done",    32'(done),    32'(m_k >= m_kd));
            chk("dvalid",  32'(dv),      32'(m_k == m_kd && m_sack));
            chk("ack",     32'(ack),     32'(m_ack_exp));
            chk("rd_data", 32'(rd_data), 32'(m_rd_exp));
            if (done === 1'b1 && m_done_k < 0) m_done_k = m_k;
            if (sda === 1'b0 && m_fall_k < 0)  m_fall_k = m_k;
            if (dv === 1'b1) m_dv_cnt++;
            slave_low = mdl_slave_low(eidx(m_k + 1));
            m_k++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_scl"},  32'(scl),     32'd1);
        chk({tag, "_sda"},  32'(sda),     32'd1);
        chk({tag, "_busy"}, 32'(busy),    32'd0);
        chk({tag, "_done"}, 32'(done),    32'd0);
        chk({tag, "_ack"},  32'(ack),     32'd0);
        chk({tag, "_rd"},   32'(rd_data), 32'd0);
        chk({tag, "_dv"},   32'(dv),      32'd0);
    endtask

    // Caller must be between a negedge and the following posedge.
    task automatic run_txn(input logic [6:0] a, input bit two, input bit sack,
                           input logic [7:0] b1, input logic [7:0] b2,
                           input logic [6:0] div, input bit inject, input int rst_at);
        bit finished;
        int limit;
        finished  = 1'b0;
        divisor   = div;
        addr      = a;
        two_bytes = two;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        // Captured values must be used, not the live inputs.
        divisor   = div ^ 7'h03;
        addr      = ~a;
        two_bytes = ~two;
        slave_low = 1'b0;
        m_T = int'(div) + 1;
        m_addr = a; m_two = two; m_sack = sack; m_b1 = b1; m_b2 = b2;
        m_fin = sack ? (two ? 29 : 20) : 11;
        m_kd  = (m_fin * 128 + 32) * m_T;
        m_ka  = (9 * 128 + 96) * m_T;
        m_k = 0; m_done_k = -1; m_fall_k = -1; m_dv_cnt = 0;
        m_active = 1'b1;
        limit = 40 * 128 * m_T;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #2;
            if (inject && m_k == 12 * 128 * m_T) begin
                start = 1'b1;
                addr  = 7'h55;
            end
            if (inject && m_k == 12 * 128 * m_T + 3) start = 1'b0;
            if (rst_at > 0 && m_k == rst_at) begin
                rst_n     = 1'b0;
                m_active  = 1'b0;
                slave_low = 1'b0;
                #1;
                check_reset_outputs("midrst");
                @(negedge clk);
                #2;
                check_reset_outputs("midrst_hold");
                rst_n     = 1'b1;
                m_ack_exp = 1'b0;
                m_rd_exp  = 16'h0000;
                return;
            end
            if (m_k > m_kd) begin
                finished = 1'b1;
                break;
            end
        end
        chk("txn_timeout", 32'(finished), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; divisor = 7'd0; start = 1'b0; addr = 7'd0;
        two_bytes = 1'b0; slave_low = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        check_reset_outputs("post_rst");

        // Two-byte read, T=2
        run_txn(7'h48, 1'b1, 1'b1, 8'hA5, 8'h3C, 7'd1, 1'b0, 0);
        chk("t2_done_time", 32'(m_done_k), 32'd7488);
        chk("t2_first_fall", 32'(m_fall_k), 32'd64);
        chk("t2_dv_count", 32'(m_dv_cnt), 32'd1);
        chk("t2_rd_data", 32'(rd_data), 32'h0000A53C);
        chk("t2_ack", 32'(ack), 32'd1);

        // One-byte read started back-to-back, T=1
        run_txn(7'h1D, 1'b0, 1'b1, 8'h7E, 8'h00, 7'd0, 1'b0, 0);
        chk("t1_done_time", 32'(m_done_k), 32'd2592);
        chk("t1_first_fall", 32'(m_fall_k), 32'd32);
        chk("t1_dv_count", 32'(m_dv_cnt), 32'd1);
        chk("t1_rd_data", 32'(rd_data), 32'h0000007E);

        repeat (7) @(negedge clk);
        #2;
        // Address NACK, T=3
        run_txn(7'h2A, 1'b1, 1'b0, 8'hFF, 8'hFF, 7'd2, 1'b0, 0);
        chk("nack_done_time", 32'(m_done_k), 32'd4320);
        chk("nack_dv_count", 32'(m_dv_cnt), 32'd0);
        chk("nack_rd_kept", 32'(rd_data), 32'h0000007E);
        chk("nack_ack", 32'(ack), 32'd0);

        // Start pulsed while busy must be ignored, T=1
        run_txn(7'h48, 1'b1, 1'b1, 8'h5A, 8'hC3, 7'd0, 1'b1, 0);
        chk("busy_start_done_time", 32'(m_done_k), 32'd3744);
        chk("busy_start_rd", 32'(rd_data), 32'h00005AC3);
        chk("busy_start_ack", 32'(ack), 32'd1);

        // Reset during DATA2, then a clean transaction
        run_txn(7'h33, 1'b1, 1'b1, 8'h11, 8'h22, 7'd0, 1'b0, 20 * 128 + 50);
        run_txn(7'h33, 1'b1, 1'b1, 8'h96, 8'h69, 7'd0, 1'b0, 0);
        chk("after_rst_done_time", 32'(m_done_k), 32'd3744);
        chk("after_rst_rd", 32'(rd_data), 32'h00009669);
        chk("after_rst_dv_count", 32'(m_dv_cnt), 32'd1);

        m_active = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_controller_read.md
# i2c_controller_read

I2C master read controller, the counterpart of the I2C write controller, in the same wb_i2c peripheral. On `start` it issues a START condition, sends a 7-bit address with R/W=1, checks the slave ACK, clocks in one or two data bytes (master ACK between bytes, NACK after the last), then issues a STOP. The whole block runs on the system clock, and a `divisor`-based tick enable generates I2C timing, so there is no derived clock.

## Interface
- No parameters. Bit period is fixed at 128 ticks.
- `clk` in 1: system clock; all logic runs on its rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces the reset state immediately.
- `divisor` in 7: tick period T = (divisor+1) clk cycles. Sampled only while idle.
- `start` in 1: a high level on any clk while idle starts a transaction.
- `addr` in 7: slave address, captured at start.
- `two_bytes` in 1: 1 reads 2 bytes, 0 reads 1 byte; captured at start.
- `i2c_sclk` out 1: SCL.
- `i2c_sdat` inout 1: SDA, open-drain; drives 0 or Z only.
- `busy` out 1: transaction in progress.
- `done` out 1: level; high from transaction end until the next accepted start.
- `ack` out 1: 1 means the slave ACKed its address in the last transaction.
- `rd_data` out 16: read result. Two bytes give {byte1, byte2}; one byte gives {8'h00, byte1}.
- `data_valid` out 1: one-clk pulse when `rd_data` updates.

## Operation
- **Tick counter.** Counts 0..divisor and wraps. `tick` is high on the wrap cycle.
- **Phase counter.** `phase[6:0]` increments on each tick while busy and wraps at 127. The wrap ends a bit period.
- **SCL.** `i2c_sclk = ~clk_en | phase[6]`, so SCL is low for phases 0–63 and high for 64–127.
- **SDA timing.** SDA changes only at phase 31 (mid-low). SDA is sampled at phase 95 (mid-high).
- **Input synchronizer.** `i2c_sdat` passes through a 2-FF synchronizer before sampling.
- **States** (one bit period each unless noted):
  - IDLE: SDA released, `clk_en`=0. On `start`: capture inputs, clear phase, set busy, clear done. Go to START.
  - START: phase 31 drives SDA=0 while SCL is high. At period end set `clk_en`=1. Go to ADDR.
  - ADDR (8 periods): drive addr[6] first through addr[0], then R/W=1 (released). Go to AACK.
  - AACK: release SDA and sample at phase 95. Sampled 0 sets `ack`=1 and goes to DATA1. Sampled 1 sets `ack`=0 and goes to STOP.
  - DATA1 (8 periods): release SDA, shift in the sampled bit MSB-first. Go to MACK1.
  - MACK1: drive 0 if two_bytes, else release (NACK). Go to DATA2 if two_bytes, else STOP.
  - DATA2 (8 periods): as DATA1. Go to MACK2.
  - MACK2: release (NACK). Go to STOP.
  - STOP: phase 31 drives SDA=0. At period end set `clk_en`=0. Go to FIN.
  - FIN: phase 31 releases SDA while SCL is high (STOP condition). Clear busy and set done. If `ack`, load rd_data and pulse data_valid. Go to IDLE.
- **Start while busy.** `start` is ignored while busy. It is not queued.
- **Address NACK.** `rd_data` is unchanged and `data_valid` is not pulsed.
- **Reset** (asserted any time, including mid-transaction):
  - Outputs: SCL=1, SDA released, busy=0, done=0, ack=0, rd_data=0, data_valid=0.
  - State: state=IDLE, counters=0.
  - The bus is abandoned with no STOP.

## Timing
- **Bit period.** 128·T clk cycles.
- **Start latency.** The first SDA fall occurs 32·T (±1 clk) after the start clk.
- **`done` rise, relative to the start clk:**
  - Two bytes: (29·128 + 32)·T.
  - One byte: (20·128 + 32)·T.
  - Address NACK: (11·128 + 32)·T.
- **`data_valid` alignment.** `data_valid` and the `rd_data` update occur on the same clk as the `done` rise.
- **Sample point.** SDA is seen at phase 95 plus 2 clk of synchronizer delay. Slaves must hold SDA through SCL high.
- **Back-to-back.** A `start` on the clk after `done` rises is accepted. SCL stays high between transactions.

## Test plan
- **Reset values.** divisor=0, hold reset=0 → SCL=1, SDA=Z, busy=0, done=0, ack=0, rd_data=0. Release reset → outputs unchanged until start.
- **Two-byte read.** addr=7'h48, two_bytes=1; slave model ACKs and returns 8'hA5, 8'h3C → bus sequence 0x91, ACK, A5, master ACK(0), 3C, NACK(Z), STOP. Result: rd_data=16'hA53C, ack=1, one data_valid pulse, done at (29·128+32)·T.
- **One-byte read.** addr=7'h1D, two_bytes=0; slave returns 8'h7E → MACK1 is NACK, immediate STOP. Result: rd_data=16'h007E, done at (20·128+32)·T.
- **Address NACK.** No slave responds → ack=0 after AACK, STOP follows, rd_data keeps its prior value, no data_valid pulse, done at (11·128+32)·T.
- **Start while busy.** Pulse start mid-DATA1 with a different addr → ignored; the transaction completes with the original addr and two_bytes.
- **Reset mid-transaction.** Assert reset during DATA2 → SCL=1 and SDA=Z on the next edge, busy=0, done=0. The next start runs a clean full transaction.
